// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// Collects floor-call presses into a pending bitmap and feeds one target floor
// at a time to the elevator controller using collective (SCAN) scheduling:
// the car keeps its travel direction while calls remain ahead, then reverses.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  open_door,
    input  logic                  rescue,
    output logic [3:0]            requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    logic [NUM_FLOORS-1:0] sync1_r;
    logic [NUM_FLOORS-1:0] sync2_r;
    logic [NUM_FLOORS-1:0] edge_q_r;
    logic                  door_q_r;
    logic [NUM_FLOORS-1:0] pending_r;
    logic [1:0]            state_r;
    logic [3:0]            req_r;
    logic                  dir_up_r;
    logic                  dir_down_r;

    logic [NUM_FLOORS-1:0] press_s;
    logic                  door_rise_s;
    logic                  floor_valid_s;
    logic [NUM_FLOORS-1:0] pending_next_s;

    logic                  here_s;
    logic                  above_found_s;
    logic [3:0]            above_floor_s;
    logic                  below_found_s;
    logic [3:0]            below_floor_s;
    logic [3:0]            dist_up_s;
    logic [3:0]            dist_down_s;
    logic [1:0]            next_state_s;
    logic [3:0]            next_req_s;

    assign press_s       = sync2_r & ~edge_q_r;
    assign door_rise_s   = open_door & ~door_q_r;
    assign floor_valid_s = (current_floor < 4'(NUM_FLOORS));

    // Two-flop synchroniser plus edge flop so a held button yields one pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r  <= '0;
            sync2_r  <= '0;
            edge_q_r <= '0;
        end else begin
            sync1_r  <= call_btn;
            sync2_r  <= sync1_r;
            edge_q_r <= sync2_r;
        end
    end

    // Previous door state for door-open edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            door_q_r <= 1'b0;
        end else begin
            door_q_r <= open_door;
        end
    end

    // Next pending bitmap: rescue flush, otherwise set on press / clear on arrival
    always_comb begin
        pending_next_s = pending_r;
        if (rescue) begin
            pending_next_s = '0;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                // A press for the floor whose door is already open is being served
                if (press_s[i] && !(open_door && (current_floor == 4'(i)))) begin
                    pending_next_s[i] = 1'b1;
                end else if (door_rise_s && (current_floor == 4'(i))) begin
                    pending_next_s[i] = 1'b0;
                end else begin
                    pending_next_s[i] = pending_r[i];
                end
            end
        end
    end

    // Pending-call bitmap register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Priority scans of the pending bitmap relative to the current floor
    always_comb begin
        here_s        = 1'b0;
        above_found_s = 1'b0;
        above_floor_s = 4'd0;
        below_found_s = 1'b0;
        below_floor_s = 4'd0;
        // Descending scan: the last hit above the car is the nearest one above
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_r[i] && (4'(i) > current_floor)) begin
                above_found_s = 1'b1;
                above_floor_s = 4'(i);
            end else begin
                above_found_s = above_found_s;
            end
        end
        // Ascending scan: the last hit below the car is the nearest one below
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_r[i] && (4'(i) < current_floor)) begin
                below_found_s = 1'b1;
                below_floor_s = 4'(i);
            end else begin
                below_found_s = below_found_s;
            end
            if (pending_r[i] && (4'(i) == current_floor)) begin
                here_s = 1'b1;
            end else begin
                here_s = here_s;
            end
        end
    end

    assign dist_up_s   = above_floor_s - current_floor;
    assign dist_down_s = current_floor - below_floor_s;

    // Scheduler next state and target; target holds when the state has none
    always_comb begin
        next_state_s = state_r;
        next_req_s   = req_r;
        if (rescue) begin
            next_state_s = ST_IDLE;
            if (floor_valid_s) begin
                next_req_s = current_floor;
            end else begin
                next_req_s = req_r;
            end
        end else if (!floor_valid_s) begin
            next_state_s = state_r;
            next_req_s   = req_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (here_s) begin
                        next_state_s = ST_IDLE;
                        next_req_s   = current_floor;
                    end else if (above_found_s && (!below_found_s || (dist_up_s <= dist_down_s))) begin
                        next_state_s = ST_UP;
                        next_req_s   = above_floor_s;
                    end else if (below_found_s) begin
                        next_state_s = ST_DOWN;
                        next_req_s   = below_floor_s;
                    end else begin
                        next_state_s = ST_IDLE;
                        next_req_s   = current_floor;
                    end
                end
                ST_UP: begin
                    if (here_s) begin
                        next_req_s = current_floor;
                    end else if (above_found_s) begin
                        next_req_s = above_floor_s;
                    end else if (below_found_s) begin
                        next_state_s = ST_DOWN;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_DOWN: begin
                    if (here_s) begin
                        next_req_s = current_floor;
                    end else if (below_found_s) begin
                        next_req_s = below_floor_s;
                    end else if (above_found_s) begin
                        next_state_s = ST_UP;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_req_s   = req_r;
                end
            endcase
        end
    end

    // State, target and direction flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            req_r      <= 4'd0;
            dir_up_r   <= 1'b0;
            dir_down_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            req_r      <= next_req_s;
            dir_up_r   <= (next_state_s == ST_UP);
            dir_down_r <= (next_state_s == ST_DOWN);
        end
    end

    assign requested_floor = req_r;
    assign pending         = pending_r;
    assign dir_up          = dir_up_r;
    assign dir_down        = dir_down_r;
    assign busy            = |pending_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Testbench for elevator_call_scheduler: directed scenarios plus randomized
// traffic, every cycle compared against a floor-distance reference model.
module tb_elevator_call_scheduler;

    localparam int NF = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_btn;
    logic [3:0]    cf;
    logic          od;
    logic          rescue;
    logic [3:0]    requested_floor;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          dir_down;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [NF-1:0] s1_m, s2_m, s3_m, pend_m;
    logic          od_m;
    int            dir_m;   // 0 idle, 1 up, -1 down
    int            req_m;

    elevator_call_scheduler #(.NUM_FLOORS(NF)) dut (
        .clk             (clk),
        .reset           (reset),
        .call_btn        (call_btn),
        .current_floor   (cf),
        .open_door       (od),
        .rescue          (rescue),
        .requested_floor (requested_floor),
        .pending         (pending),
        .dir_up          (dir_up),
        .dir_down        (dir_down),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at this edge, then compare.
    task automatic tick();
        logic [NF-1:0] press;
        logic [NF-1:0] np;
        logic          rise;
        int            nd;
        int            nr;
        int            c;
        int            up_d;
        int            dn_d;
        logic          here;
        @(posedge clk);
        c = int'(cf);
        if (reset) begin
            s1_m = '0; s2_m = '0; s3_m = '0; pend_m = '0;
            od_m = 1'b0; dir_m = 0; req_m = 0;
        end else begin
            press = s2_m & ~s3_m;
            rise  = od && !od_m;
            np    = pend_m;
            nd    = dir_m;
            nr    = req_m;
            if (rescue) begin
                np = '0;
                nd = 0;
                if (c < NF) nr = c;
            end else begin
                for (int i = 0; i < NF; i++) begin
                    if (press[i] && !(od && c == i)) np[i] = 1'b1;
                    else if (rise && c == i) np[i] = 1'b0;
                end
                if (c < NF) begin
                    up_d = 0;
                    dn_d = 0;
                    for (int d = NF; d >= 1; d--) begin
                        if (c + d < NF && pend_m[c + d]) up_d = d;
                        if (c - d >= 0 && pend_m[c - d]) dn_d = d;
                    end
                    here = pend_m[c];
                    if (dir_m == 0) begin
                        if (here) nr = c;
                        else if (up_d != 0 && (dn_d == 0 || up_d <= dn_d)) begin nd = 1; nr = c + up_d; end
                        else if (dn_d != 0) begin nd = -1; nr = c - dn_d; end
                        else nr = c;
                    end else if (dir_m == 1) begin
                        if (here) nr = c;
                        else if (up_d != 0) nr = c + up_d;
                        else if (dn_d != 0) nd = -1;
                        else nd = 0;
                    end else begin
                        if (here) nr = c;
                        else if (dn_d != 0) nr = c - dn_d;
                        else if (up_d != 0) nd = 1;
                        else nd = 0;
                    end
                end
            end
            s3_m = s2_m; s2_m = s1_m; s1_m = call_btn;
            od_m = od; pend_m = np; dir_m = nd; req_m = nr;
        end
        #1;
        chk("model_pending",  16'(pending),         16'(pend_m));
        chk("model_req",      16'(requested_floor), 16'(req_m[3:0]));
        chk("model_dir_up",   16'(dir_up),          16'(dir_m == 1));
        chk("model_dir_down", 16'(dir_down),        16'(dir_m == -1));
        chk("model_busy",     16'(busy),            16'(pend_m != '0));
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; call_btn = '0; rescue = 1'b0; od = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [NF-1:0] bits);
        call_btn = bits;
        tick();
        call_btn = '0;
        cyc(4);
    endtask

    initial begin
        int rescue_left;
        reset = 1'b1; call_btn = '0; cf = 4'd0; od = 1'b0; rescue = 1'b0;
        tick(); tick();
        chk("rst_pending", 16'(pending), 16'd0);
        chk("rst_req",     16'(requested_floor), 16'd0);
        chk("rst_dirs",    16'({dir_up, dir_down, busy}), 16'd0);
        reset = 1'b0;
        tick();

        // press floor 5 from floor 0: pending at +3, target/direction at +4
        call_btn[5] = 1'b1;
        tick(); tick();
        chk("press_not_yet", 16'(pending), 16'd0);
        tick();
        chk("press_pending", 16'(pending), 16'(10'b0000100000));
        chk("press_busy",    16'(busy), 16'd1);
        tick();
        chk("press_req",     16'(requested_floor), 16'd5);
        chk("press_dir_up",  16'(dir_up), 16'd1);
        call_btn = '0;

        // SCAN sweep: at 2 going up with {7,4,1}
        do_reset();
        cf = 4'd2;
        pulse(10'b0000010000);
        pulse(10'b0010000010);
        chk("scan_req4", 16'(requested_floor), 16'd4);
        chk("scan_up",   16'(dir_up), 16'd1);
        cf = 4'd4; cyc(2);
        od = 1'b1; tick();
        chk("scan_clr4", 16'(pending), 16'(10'b0010000010));
        tick();
        chk("scan_req7", 16'(requested_floor), 16'd7);
        od = 1'b0; cyc(2);
        cf = 4'd7; cyc(2);
        od = 1'b1; cyc(3);
        chk("scan_down", 16'(dir_down), 16'd1);
        chk("scan_req1", 16'(requested_floor), 16'd1);
        od = 1'b0; cf = 4'd1; cyc(2);
        od = 1'b1; cyc(3);
        chk("scan_idle", 16'({dir_up, dir_down}), 16'd0);
        chk("scan_busy", 16'(busy), 16'd0);
        chk("scan_req_end", 16'(requested_floor), 16'd1);
        od = 1'b0;

        // equal-distance tie from IDLE at 4 goes up
        do_reset();
        cf = 4'd4; cyc(2);
        pulse(10'b0001000100);
        chk("tie_up",  16'(dir_up), 16'd1);
        chk("tie_req", 16'(requested_floor), 16'd6);

        // press for the floor with the door open is dropped
        do_reset();
        cf = 4'd3; od = 1'b1; cyc(2);
        pulse(10'b0000001000);
        chk("door_drop_pending", 16'(pending), 16'd0);
        chk("door_drop_req",     16'(requested_floor), 16'd3);
        od = 1'b0; cyc(2);
        pulse(10'b0000001000);
        chk("door_closed_pending", 16'(pending), 16'(10'b0000001000));

        // rescue flushes and blocks calls
        do_reset();
        cf = 4'd5;
        pulse(10'b1100000000);
        chk("resc_pre", 16'(pending), 16'(10'b1100000000));
        rescue = 1'b1; tick();
        chk("resc_flush", 16'(pending), 16'd0);
        chk("resc_req",   16'(requested_floor), 16'd5);
        pulse(10'b0000000100);
        chk("resc_block", 16'(pending), 16'd0);
        rescue = 1'b0; cyc(2);
        pulse(10'b1000000000);
        chk("resc_after_pending", 16'(pending), 16'(10'b1000000000));
        chk("resc_after_req",     16'(requested_floor), 16'd9);

        // held button yields one call only
        do_reset();
        cf = 4'd0;
        call_btn[6] = 1'b1;
        cyc(4);
        chk("hold_set", 16'(pending), 16'(10'b0001000000));
        cf = 4'd6; cyc(2);
        od = 1'b1; cyc(3); od = 1'b0;
        chk("hold_cleared", 16'(pending), 16'd0);
        cyc(1000);
        chk("hold_no_repeat", 16'(pending), 16'd0);
        call_btn = '0;

        // reset mid-travel
        pulse(10'b1000000000);
        cf = 4'd7; cyc(2);
        reset = 1'b1; tick();
        chk("midrst_pending", 16'(pending), 16'd0);
        chk("midrst_outs", 16'({requested_floor, dir_up, dir_down, busy}), 16'd0);
        reset = 1'b0; tick();

        // randomized traffic against the model
        rescue_left = 0;
        for (int n = 0; n < 3000; n++) begin
            call_btn = ($urandom_range(0, 5) == 0) ? NF'($urandom()) : '0;
            if ($urandom_range(0, 9) == 0) od = ~od;
            if ($urandom_range(0, 15) == 0)
                cf = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, NF - 1));
            if (rescue_left > 0) rescue_left--;
            else if ($urandom_range(0, 99) == 0) rescue_left = $urandom_range(1, 6);
            rescue = (rescue_left > 0);
            reset  = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
